// File: rtl/multi_seq.sv
// multi_seq: sequential signed WIDTHxWIDTH shift-add multiplier (define MULTI_VAR_LATENCY_EN for early termination)
module multi_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   mlier,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               start,
    output logic [2*WIDTH-1:0] prodt,
    output logic               valid
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic               start_q;
    logic               sign_q;
    logic               valid_q;
    logic [WIDTH-1:0]   mlier_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] prodt_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   mlier_mag;
    logic [WIDTH-1:0]   mcand_mag;
    logic [2*WIDTH-1:0] acc_d;
    logic               last;

    // magnitudes (most negative value becomes 2^(WIDTH-1) unsigned), next accumulator, final-iteration flag
    always_comb begin
        mlier_mag = mlier[WIDTH-1] ? -mlier : mlier;
        mcand_mag = mcand[WIDTH-1] ? -mcand : mcand;
        acc_d     = acc_q + (mlier_q[0] ? mcand_q : '0);
`ifdef MULTI_VAR_LATENCY_EN
        last      = ((mlier_q >> 1) == '0) || (cnt_q == CW'(WIDTH - 1));
`else
        last      = cnt_q == CW'(WIDTH - 1);
`endif
    end

    // control FSM and datapath: capture on start rising edge, one shift-add per clock, one-cycle DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            mlier_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            prodt_q <= '0;
            cnt_q   <= '0;
        end else begin
            start_q <= start;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !start_q) begin
                        sign_q  <= mlier[WIDTH-1] ^ mcand[WIDTH-1];
                        mlier_q <= mlier_mag;
                        mcand_q <= {{WIDTH{1'b0}}, mcand_mag};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q   <= acc_d;
                    mlier_q <= mlier_q >> 1;
                    mcand_q <= mcand_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        prodt_q <= sign_q ? -acc_d : acc_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prodt = prodt_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_multi_seq.sv
// tb_multi_seq: directed and random checks of multi_seq against a reference model of signed products and latency
module tb_multi_seq;
`ifdef MULTI_VAR_LATENCY_EN
    localparam bit VAR_LAT = 1'b1;
`else
    localparam bit VAR_LAT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mlier = '0;
    logic [31:0] mcand = '0;
    logic        start = 1'b0;
    logic [63:0] prodt;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    multi_seq dut (
        .clock(clock),
        .reset(reset),
        .mlier(mlier),
        .mcand(mcand),
        .start(start),
        .prodt(prodt),
        .valid(valid)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        longint m = longint'($signed(a));
        int n = 0;
        if (m < 0) m = -m;
        while (m != 0) begin
            m = m >>> 1;
            n++;
        end
        return VAR_LAT ? ((n < 1) ? 1 : n) : 32;
    endfunction

    // reference model: phase 0 idle, 1 computing (countdown of edges), 2 the one cycle after completion
    int          m_phase = 0;
    int          m_left  = 0;
    bit          m_prev  = 1'b0;
    bit          armed   = 1'b0;
    logic [63:0] m_res   = '0;
    logic [63:0] exp_prodt = '0;
    logic        exp_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase   = 0;
            m_prev    = 1'b0;
            exp_valid = 1'b0;
            exp_prodt = '0;
            armed     = 1'b1;
        end else begin
            exp_valid = 1'b0;
            if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    exp_prodt = m_res;
                    exp_valid = 1'b1;
                    m_phase   = 2;
                end
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (start && !m_prev) begin
                m_res   = ref_prod(mlier, mcand);
                m_left  = lat_of(mlier);
                m_phase = 1;
            end
            m_prev = start;
        end
    end

    // per-cycle comparison of DUT outputs against the model
    always @(negedge clock) begin
        if (armed) begin
            checks++;
            if (valid !== exp_valid || prodt !== exp_prodt) begin
                failures++;
                $display("FAIL cycle t=%0t: valid=%b prodt=%h, want valid=%b prodt=%h",
                         $time, valid, prodt, exp_valid, exp_prodt);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // raise start with operands, hold for `hold` edges, then low for `low` edges; check result, latency, pulse count
    task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input int low, input logic [63:0] want, input int want_lat);
        int lat = -1;
        int pulses = 0;
        logic [63:0] res = '0;
        @(posedge clock);
        #1;
        mlier = a;
        mcand = b;
        start = 1'b1;
        for (int i = 1; i <= hold + low; i++) begin
            @(posedge clock);
            #1;
            if (i == 1) begin
                mlier = $urandom;
                mcand = $urandom;
            end
            if (valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = i - 1;
                    res = prodt;
                end
            end
            if (i == hold) start = 1'b0;
        end
        check({name, " product"}, res, want);
        check({name, " latency"}, 64'(lat), 64'(want_lat));
        check({name, " pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset valid", 64'(valid), 64'd0);
        check("reset prodt", prodt, 64'd0);

        op("max_pos_sq", 32'h7fffffff, 32'h7fffffff, 40, 3, 64'h3FFFFFFF00000001, VAR_LAT ? 31 : 32);
        op("one_x_minneg", 32'h00000001, 32'h80000000, 33, 3, 64'hFFFFFFFF80000000, VAR_LAT ? 1 : 32);
        op("neg1_sq", 32'hffffffff, 32'hffffffff, 33, 3, 64'h0000000000000001, VAR_LAT ? 1 : 32);
        op("minneg_sq", 32'h80000000, 32'h80000000, 33, 3, 64'h4000000000000000, 32);
        op("pos_x_neg1", 32'h7fffffff, 32'hffffffff, 33, 3, 64'hFFFFFFFF80000001, VAR_LAT ? 31 : 32);
        op("zero_x_neg", 32'h00000000, 32'h80000000, 33, 3, 64'h0000000000000000, VAR_LAT ? 1 : 32);
        op("minneg_x_maxpos", 32'h80000000, 32'h7fffffff, 33, 3, 64'hC000000080000000, 32);

        // reset during computation discards the result
        @(posedge clock);
        #1;
        mlier = 32'h7fffffff;
        mcand = 32'h12345678;
        start = 1'b1;
        repeat (11) @(posedge clock);
        #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset valid", 64'(valid), 64'd0);
        check("midreset prodt", prodt, 64'd0);
        repeat (40) @(posedge clock);
        #1;
        check("post-reset idle valid", 64'(valid), 64'd0);
        check("post-reset idle prodt", prodt, 64'd0);
        op("after_reset", 32'h5555aaaa, 32'h7fffffff, 33, 5, 64'h2AAAD554AAAA5556, VAR_LAT ? 31 : 32);

        for (int k = 0; k < 32; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 4 == 1) a = a >> (k % 31);
            op("random", a, b, 33, 5, ref_prod(a, b), lat_of(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
